// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the 1R1W SRAM stream FIFO controller.
// Holds the default macro geometry (sram_0rw1r1w_22_16_freepdk45), the pointer
// type for that geometry and the depth of the read-latency hiding output buffer.
package sram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 22;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int OBUF_DEPTH         = 2;

    // One extra bit above the macro address distinguishes full from empty.
    typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/sram_1r1w_fifo_ctrl_if.sv
// Valid/ready stream bundle for the SRAM FIFO controller.
// Signals: in_valid/in_ready/in_data (producer side),
//          out_valid/out_ready/out_data (consumer side).
// Modports: master = producer/consumer driving the FIFO, slave = the FIFO.
interface sram_1r1w_fifo_ctrl_if
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sram_fifo_obuf.sv
// Two-entry in-order output buffer that absorbs the SRAM's one-cycle read
// latency so the consumer sees registered data with no bubbles.
// Ports: clk, rst (sync, active-high), capture/capture_data (word arriving
// from the macro), pop (consumer took the head), head_data/head_valid (head
// word), cnt (occupancy 0..2).
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] mem_r [OBUF_DEPTH];
    logic                  head_r;
    logic [1:0]            cnt_r;
    logic                  tail_s;

    // Tail slot: with two entries, the free slot is head when cnt is 0 or 2.
    // A capture at cnt==2 only happens alongside a pop, so writing the head
    // slot is safe: it is vacated on the same edge.
    always_comb begin
        tail_s = head_r ^ cnt_r[0];
    end

    // Buffer storage, head pointer and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            head_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            if (capture) begin
                mem_r[tail_s] <= capture_data;
            end
            if (pop) begin
                head_r <= ~head_r;
            end
            case ({capture, pop})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign head_data  = mem_r[head_r];
    assign head_valid = (cnt_r != 2'd0);
    assign cnt        = cnt_r;

endmodule

// File: rtl/sram_1r1w_fifo_ctrl.sv
// Stream FIFO controller driving a 0rw1r1w SRAM macro
// (sram_0rw1r1w_22_16_freepdk45 family); macro clk0/clk1 tie to clk.
// Ports: clk, rst (sync, active-high), st (stream bundle, slave modport),
//        csb0/addr0/din0 (macro write port, combinational, sampled by the
//        macro at posedge), csb1/addr1 (macro read port), dout1 (read data,
//        valid the cycle after a read issue).
// Optional: define SRAM_FIFO_COUNT_EN to add the registered 'count' output
//        (words held in SRAM + in flight + in the output buffer).
module sram_1r1w_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_1r1w_fifo_ctrl_if.slave  st,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH+1:0] count
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_P = PW'(DEPTH);

    logic [ADDR_WIDTH:0]   wr_ptr_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH:0]   sram_cnt_s;
    logic                  in_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  rd_issue_s;
    logic [2:0]            occ_s;
    logic [1:0]            obuf_cnt_s;
    logic                  obuf_valid_s;
    logic [DATA_WIDTH-1:0] obuf_head_s;

    // Handshakes and read-issue decision. A read is issued only if the word
    // will have a buffer slot when it lands, counting the slot a pop frees
    // this cycle. sram_cnt is registered, so a read never targets a word
    // being written in the same cycle.
    always_comb begin
        sram_cnt_s = wr_ptr_r - rd_ptr_r;
        in_ready_s = !rst && (sram_cnt_s != DEPTH_P);
        push_s     = st.in_valid && in_ready_s;
        pop_s      = obuf_valid_s && st.out_ready;
        occ_s      = 3'(obuf_cnt_s) + 3'(inflight_r);
        rd_issue_s = !rst && (sram_cnt_s != '0)
                     && (occ_s < (3'(OBUF_DEPTH) + 3'(pop_s)));
    end

    // Macro drive; held idle with zero address/data while in reset.
    always_comb begin
        csb0 = !push_s;
        csb1 = !rd_issue_s;
        if (rst) begin
            addr0 = '0;
            din0  = '0;
            addr1 = '0;
        end else begin
            addr0 = wr_ptr_r[ADDR_WIDTH-1:0];
            din0  = st.in_data;
            addr1 = rd_ptr_r[ADDR_WIDTH-1:0];
        end
    end

    // Pointers and the read-in-flight flag; clearing inflight on reset
    // discards any read the macro returns after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            inflight_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            inflight_r <= rd_issue_s;
        end
    end

    sram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk          (clk),
        .rst          (rst),
        .capture      (inflight_r),
        .capture_data (dout1),
        .pop          (pop_s),
        .head_data    (obuf_head_s),
        .head_valid   (obuf_valid_s),
        .cnt          (obuf_cnt_s)
    );

    assign st.in_ready  = in_ready_s;
    assign st.out_valid = obuf_valid_s;
    assign st.out_data  = obuf_head_s;

`ifdef SRAM_FIFO_COUNT_EN
    logic [ADDR_WIDTH+1:0] count_r;

    // Total occupancy changes only by accepted pushes and pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + (ADDR_WIDTH+2)'(push_s) - (ADDR_WIDTH+2)'(pop_s);
        end
    end

    assign count = count_r;
`endif

endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// Self-checking bench for sram_1r1w_fifo_ctrl with a behavioural SRAM macro
// and an occupancy-level reference model of the FIFO.
module tb_sram_1r1w_fifo_ctrl;

    localparam int DW    = 22;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_1r1w_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic          csb0, csb1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout1;
`ifdef SRAM_FIFO_COUNT_EN
    logic [AW+1:0] count;
`endif

    sram_1r1w_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .st    (bus),
        .csb0  (csb0),
        .addr0 (addr0),
        .din0  (din0),
        .csb1  (csb1),
        .addr1 (addr1),
        .dout1 (dout1)
`ifdef SRAM_FIFO_COUNT_EN
        ,
        .count (count)
`endif
    );

    // Behavioural 1R1W macro: write and registered read at posedge.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!csb0) sram_mem[addr0] <= din0;
        if (!csb1) dout1 <= sram_mem[addr1];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word counts per stage plus the ordered list of words.
    int            m_s = 0, m_fl = 0, m_ob = 0, m_wr = 0, m_rd = 0;
    logic [DW-1:0] m_q [$];
    bit            armed = 1'b0;
    bit            m_pop, m_push, m_issue, m_rdy;

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        #2;
        if (!armed) begin
            if (rst === 1'b1) armed = 1'b1;
        end else begin
            m_rdy   = !rst && (m_s != DEPTH);
            m_pop   = (m_ob > 0) && bus.out_ready;
            m_push  = bus.in_valid && m_rdy;
            m_issue = !rst && (m_s > 0) && (m_ob + m_fl - int'(m_pop) < 2);
            chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ob > 0));
            if (m_ob > 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
            chk("csb0", 32'(csb0), 32'(!m_push));
            chk("csb1", 32'(csb1), 32'(!m_issue));
            if (m_push) begin
                chk("addr0", 32'(addr0), 32'(m_wr % DEPTH));
                chk("din0", 32'(din0), 32'(bus.in_data));
            end
            if (m_issue) chk("addr1", 32'(addr1), 32'(m_rd % DEPTH));
            if (!csb0 && !csb1) chk("addr_conflict", 32'(addr0 == addr1), 32'd0);
            if (rst) begin
                chk("rst_addr0", 32'(addr0), 32'd0);
                chk("rst_addr1", 32'(addr1), 32'd0);
                chk("rst_din0", 32'(din0), 32'd0);
            end
`ifdef SRAM_FIFO_COUNT_EN
            chk("count", 32'(count), 32'(m_s + m_fl + m_ob));
`endif
            if (rst) begin
                m_s = 0; m_fl = 0; m_ob = 0; m_wr = 0; m_rd = 0;
                m_q.delete();
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) m_q.push_back(bus.in_data);
                m_ob = m_ob - int'(m_pop) + m_fl;
                m_fl = int'(m_issue);
                m_s  = m_s + int'(m_push) - int'(m_issue);
                if (m_push) m_wr++;
                if (m_issue) m_rd++;
            end
        end
    end

    task automatic step(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    int n, gaps, pushed, popped, guard;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        // Reset state
        step(1'b0, 1'b0, 22'h3FFFFF, 1'b0); #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_csb0", 32'(csb0), 32'd1);
        chk("rst_csb1", 32'(csb1), 32'd1);
`ifdef SRAM_FIFO_COUNT_EN
        chk("rst_count", 32'(count), 32'd0);
`endif

        // Latency: push at edge T, out_valid visible after edge T+2
        step(1'b0, 1'b1, 22'h2AAAAA, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0); #3;
        chk("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0); #3;
        chk("lat_t2_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1); #3;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h2AAAAA);
        step(1'b0, 1'b0, '0, 1'b0); #3;
        chk("lat_empty", 32'(bus.out_valid), 32'd0);

        // Fill to DEPTH+2 with the consumer stalled
        for (int i = 1; i <= 18; i++) begin
            step(1'b0, 1'b1, 22'(i), 1'b0); #3;
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
        end
        step(1'b0, 1'b1, 22'd19, 1'b0); #3;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head", 32'(bus.out_data), 32'd1);
`ifdef SRAM_FIFO_COUNT_EN
        chk("full_count", 32'(count), 32'd18);
`endif

        // Drain: 18 consecutive words in order
        for (int i = 1; i <= 18; i++) begin
            step(1'b0, 1'b0, '0, 1'b1); #3;
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), 32'(i));
        end
        step(1'b0, 1'b0, '0, 1'b1); #3;
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Streaming: 100 words, no gaps after the initial latency
        n = 0; gaps = 0;
        for (int i = 0; i < 104; i++) begin
            if (i < 100) step(1'b0, 1'b1, 22'($urandom), 1'b1);
            else         step(1'b0, 1'b0, '0, 1'b1);
            #3;
            if (bus.out_valid) n++;
            if (i >= 3 && i <= 102 && !bus.out_valid) gaps++;
        end
        chk("stream_pops", 32'(n), 32'd100);
        chk("stream_gaps", 32'(gaps), 32'd0);

        // Backpressure: random producer and consumer
        pushed = 0; popped = 0; guard = 0;
        while (pushed < 1000 && guard < 20000) begin
            step(1'b0, 1'($urandom_range(0, 1)), 22'($urandom), 1'($urandom_range(0, 1))); #3;
            if (bus.in_valid && bus.in_ready) pushed++;
            if (bus.out_valid && bus.out_ready) popped++;
            guard++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, '0, 1'b1); #3;
            if (bus.out_valid) popped++;
        end
        chk("bp_pushed", 32'(pushed), 32'd1000);
        chk("bp_balance", 32'(popped), 32'(pushed));
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream with 10 words held and a read in flight
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 22'(100 + i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0); #3;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_csb0", 32'(csb0), 32'd1);
        chk("mid_rst_csb1", 32'(csb1), 32'd1);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SRAM_FIFO_COUNT_EN
        chk("mid_rst_count", 32'(count), 32'd0);
`endif
        step(1'b0, 1'b1, 22'h155555, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1); #3;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h155555);
        step(1'b0, 1'b0, '0, 1'b0); #3;
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

        step(1'b0, 1'b0, '0, 1'b0);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_1r1w_fifo_ctrl.md
# sram_1r1w_fifo_ctrl

Single-clock stream FIFO controller that acts as the initiator for a 0rw1r1w SRAM macro of the sram_0rw1r1w_22_16_freepdk45 family. It drives the macro's write port (csb0/addr0/din0) and read port (csb1/addr1), and takes dout1 back. It presents valid/ready streams on both sides and hides the macro's one-cycle read latency behind a 2-entry output buffer. At the top level, clk0 and clk1 of the macro are both tied to clk.

## Interface
Parameters:
- DATA_WIDTH, 22: word width; must match the macro.
- ADDR_WIDTH, 4: macro address width.
- DEPTH, 1<<ADDR_WIDTH: number of SRAM entries.

Ports:
- clk  in  1  single clock; also feeds macro clk0/clk1.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  out_data holds the head word.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_WIDTH  head word.
- csb0  out  1  macro write select, active low.
- addr0  out  ADDR_WIDTH  macro write address.
- din0  out  DATA_WIDTH  macro write data.
- csb1  out  1  macro read select, active low.
- addr1  out  ADDR_WIDTH  macro read address.
- dout1  in  DATA_WIDTH  macro read data.

## Operation
- Handshake rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Neither out_data nor out_valid may depend on out_ready in the same cycle.
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
- sram_cnt = wr_ptr - rd_ptr, taken modulo 2*DEPTH.
- Write port:
  - csb0 = !push, addr0 = wr_ptr[ADDR_WIDTH-1:0], din0 = in_data.
  - These are combinational; the macro samples them at posedge clk.
  - wr_ptr increments on push.
- Read issue:
  - rd_issue = (sram_cnt != 0) && (obuf_cnt + inflight - pop < 2).
  - csb1 = !rd_issue, addr1 = rd_ptr[ADDR_WIDTH-1:0].
  - rd_ptr increments on rd_issue.
  - inflight <= rd_issue.
- Capture: when inflight is 1, dout1 is written into the output buffer at the posedge that follows.
- Output buffer:
  - 2-entry in-order buffer; obuf_cnt ranges 0..2.
  - out_valid = (obuf_cnt != 0).
  - out_data = buffer head.
- Full / empty:
  - in_ready = (sram_cnt != DEPTH).
  - Total capacity is DEPTH+2.
  - When empty, out_valid stays 0 and no read is issued.
- Read/write address conflict:
  - A read is issued only for entries whose write was issued in an earlier cycle.
  - Therefore csb0==0 && csb1==0 && addr0==addr1 never occurs.
- An SRAM address is free for rewrite in the cycle after its read issue.
- Simultaneous push and pop while full (sram_cnt==DEPTH) is not accepted, because in_ready is 0. The push is retried in the next cycle.

## Timing
- Reset values:
  - in_ready=1 after the reset cycle; 0 while rst is high.
  - out_valid=0, csb0=1, csb1=1.
  - addr0, addr1, din0 = 0.
  - Pointers, inflight and obuf_cnt = 0.
- Latency: a push at posedge T into an empty FIFO gives out_valid=1 after posedge T+2.
  - T: write issued.
  - T+1: read issued.
  - T+2: data captured.
- Throughput: 1 word/cycle sustained with in_valid and out_ready held high; no bubbles after the initial latency.
- Reset asserted mid-operation:
  - All contents are dropped.
  - A read in flight at reset is discarded because inflight is cleared.
  - The macro is idle during reset because both csb are 1.

## Configuration
- SRAM_FIFO_COUNT_EN defined:
  - Adds output port count, ADDR_WIDTH+2 bits, registered.
  - count = sram_cnt + inflight + obuf_cnt; reset value 0.
  - Updated every cycle and exact after each posedge.
- SRAM_FIFO_COUNT_EN undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Package sram_fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - ptr_t, an (ADDR_WIDTH+1)-bit pointer type;
  - the OBUF_DEPTH=2 constant.
- Sub-module sram_fifo_obuf: the 2-entry output buffer, with a capture input and a pop input, exposing head data, valid and cnt.
- The controller top holds the pointers, issue logic and macro drive.

## Test plan
- Fill: 18 pushes of 0x000001..0x000012 with out_ready=0.
  - in_ready drops after the 18th push.
  - count=18.
  - A 19th push is held off.
- Drain: after the fill, out_ready=1.
  - Outputs are 0x000001..0x000012 in order on 18 consecutive cycles.
  - out_valid is then 0.
- Latency: a single push of 0x2AAAAA into an empty FIFO at cycle 0 → out_valid=1 and out_data=0x2AAAAA at cycle 2.
- Streaming: 100 words pushed and popped continuously → no gaps after cycle 2, exact order, and an assertion that no cycle has csb0=csb1=0 with addr0==addr1.
- Backpressure: random out_ready at 50% and random in_valid over 1000 words → a scoreboard matches every word and never loses or duplicates one.
- Reset mid-stream: rst for 1 cycle with 10 words held and one read in flight.
  - The next cycle shows out_valid=0, csb0=csb1=1 and count=0.
  - A new push of 0x155555 appears at out_data 2 cycles later.
